fetch_pc_unit: RTL

//  Instruction-fetch front end: owns the PC, issues req/ack reads to instruction memory, and holds one

---
 rtl/fetch_pc_unit_pkg.sv | 18 +
 rtl/fetch_pc_unit_buf.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared state encoding, PC step and reset address for the instruction-fetch front end.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_buf.sv
// One-entry IF->ID holding register: valid flag plus instruction word and its address.
module fetch_pc_unit_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [31:0] wr_instr_i,
  input  logic [31:0] wr_pc_i,
  input  logic        consume_i,
  input  logic        clear_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, pc_q;

  // Clear beats a write; a write in the consume cycle keeps the entry valid.
  always_comb begin
    valid_d = valid_q;
    if (clear_i)
      valid_d = 1'b0;
    else if (wr_en_i)
      valid_d = 1'b1;
    else if (consume_i)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (wr_en_i && !clear_i) begin
        instr_q <= wr_instr_i;
        pc_q    <= wr_pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC ownership, req/ack instruction-memory reads, redirect arbitration.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  output logic        addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, tgt_q, tgt_d;
  logic         req_q, err_q, err_d;
  logic         br_redir, redir, slot_free, consume, buf_wr, buf_valid;
  logic [31:0]  raw_tgt, redir_tgt;

  // The EX branch is older than the ID jump, so it wins when both fire.
  assign br_redir  = br_valid & br_taken;
  assign redir     = br_redir | jmp_valid;
  assign raw_tgt   = br_redir ? br_target : jmp_target;
  assign redir_tgt = word_align(raw_tgt);
  assign consume   = buf_valid & id_ready;
  assign slot_free = ~buf_valid | id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    err_d   = err_q | (redir & (raw_tgt[1:0] != 2'b00));
    buf_wr  = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (redir) pc_d = redir_tgt;
      end
      S_REQ: begin
        if (redir) begin
          if (imem_ack) begin
            pc_d    = redir_tgt;
            state_d = S_REQ;
          end else begin
            tgt_d   = redir_tgt;
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          // A word that finds the buffer still occupied is dropped and re-fetched later.
          if (slot_free) begin
            buf_wr  = 1'b1;
            pc_d    = pc_q + PC_STEP;
            state_d = id_ready ? S_REQ : S_HOLD;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (id_ready) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redir) tgt_d = redir_tgt;
        if (imem_ack) begin
          pc_d    = redir ? redir_tgt : tgt_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= (state_d == S_REQ) || (state_d == S_DROP);
      err_q   <= err_d;
    end
  end

  fetch_pc_unit_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (buf_wr),
    .wr_instr_i (imem_rdata),
    .wr_pc_i    (pc_q),
    .consume_i  (consume),
    .clear_i    (redir),
    .valid_o    (buf_valid),
    .instr_o    (if_instr),
    .pc_o       (if_pc)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = buf_valid;
  assign addr_err  = err_q;

endmodule
